seg7_scan_driver: RTL and testbench

- Downstream display stage for the stopwatch. It takes four 4-bit digit values plus decimal-point flags and time-multiplexes them onto a common-segment 4-digit seven-segment display.
- It produces the active-low anode strobes (board pins D0_AN_0..3) and the active-low segment bus (D0_SEG).
- The scan runs from a registered scan FSM. An inter-digit blanking gap suppresses ghosting.
- Inputs are captured into a per-frame shadow buffer so that one scan frame never mixes old and new digit values.

---
 rtl/seg7_scan_driver.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-segment 4-digit seven-segment display.
// A LOAD/SHOW/BLANK scan FSM walks digit0..digit3 from a per-frame shadow copy of the inputs.
module seg7_scan_driver #(
    parameter int DIGIT_CYCLES = 10000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp,
    input  logic       lz_blank,
    input  logic       en,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       frame_done
);

    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ?
                             ((DIGIT_CYCLES > 2) ? DIGIT_CYCLES : 2) :
                             ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CW = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] SHOW  = 2'd1;
    localparam logic [1:0] BLANK = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [15:0]   shd_digits_q;
    logic [3:0]    shd_dp_q;
    logic          shd_lz_q;

    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero; digit0 always shows.
    function automatic logic lz_suppress(input logic lz, input logic [15:0] digits,
                                         input logic [1:0] pos);
        logic sup;
        case (pos)
            2'd3:    sup = lz && (digits[15:12] == 4'h0);
            2'd2:    sup = lz && (digits[15:8] == 8'h00);
            2'd1:    sup = lz && (digits[15:4] == 12'h000);
            default: sup = 1'b0;
        endcase
        return sup;
    endfunction

    // Step the scan to the next digit, or back to LOAD once digit3 is done.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD: begin
                state_d = SHOW;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
            SHOW: begin
                if (cnt_q == DIGIT_LAST) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES == 0) begin
                        if (idx_q == 2'd3) begin
                            state_d = LOAD;
                            idx_d   = 2'd0;
                        end else begin
                            state_d = SHOW;
                            idx_d   = idx_q + 2'd1;
                        end
                    end else begin
                        state_d = BLANK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = LOAD;
                        idx_d   = 2'd0;
                    end else begin
                        state_d = SHOW;
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        logic [3:0] cur_digit;
        cur_digit    = shd_digits_q[{idx_q, 2'b00} +: 4];
        an_d         = 4'hF;
        seg_d        = 8'hFF;
        frame_done_d = (state_q == LOAD);
        if ((state_q == SHOW) && en) begin
            an_d       = ~(4'b0001 << idx_q);
            seg_d[7]   = ~shd_dp_q[idx_q];
            seg_d[6:0] = lz_suppress(shd_lz_q, shd_digits_q, idx_q) ? 7'h7F : hex7(cur_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            shd_digits_q <= '0;
            shd_dp_q     <= '0;
            shd_lz_q     <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            if (state_q == LOAD) begin
                shd_digits_q <= {digit3, digit2, digit1, digit0};
                shd_dp_q     <= dp;
                shd_lz_q     <= lz_blank;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (4/2 and 1/0 timing) checked every cycle against a
// frame-position model, plus literal expectations for the documented scan sequences.
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] dp;
    logic       lz_blank;
    logic       en;
    logic [3:0] an_a, an_b;
    logic [7:0] seg_a, seg_b;
    logic       fd_a, fd_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int cur;

    seg7_scan_driver #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .digit0(digit0), .digit1(digit1), .digit2(digit2),
        .digit3(digit3), .dp(dp), .lz_blank(lz_blank), .en(en),
        .an(an_a), .seg(seg_a), .frame_done(fd_a)
    );

    seg7_scan_driver #(.DIGIT_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .digit0(digit0), .digit1(digit1), .digit2(digit2),
        .digit3(digit3), .dp(dp), .lz_blank(lz_blank), .en(en),
        .an(an_b), .seg(seg_b), .frame_done(fd_b)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Model: each instance is at some position within a frame of 4*(D+B)+1 cycles;
    // position 0 is the load cycle, the rest split into four slots of D lit + B dark cycles.
    logic [6:0]  HEX7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          pos [2];
    logic [15:0] sh_dv [2];
    logic [3:0]  sh_dp [2];
    logic        sh_lz [2];
    logic [3:0]  exp_an [2];
    logic [7:0]  exp_seg [2];
    logic        exp_fd [2];
    int          m_dc, m_bc, m_per, m_q, m_k, m_r;

    function automatic int dcv(input int m);
        return (m == 0) ? 4 : 1;
    endfunction

    function automatic int bcv(input int m);
        return (m == 0) ? 2 : 0;
    endfunction

    function automatic logic supp(input logic lz, input logic [15:0] dv, input int k);
        return lz && (k > 0) && ((dv >> (4 * k)) == 16'h0);
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            m_dc  = dcv(m);
            m_bc  = bcv(m);
            m_per = 4 * (m_dc + m_bc) + 1;
            if (rst) begin
                pos[m]     = 0;
                sh_dv[m]   = 16'h0;
                sh_dp[m]   = 4'h0;
                sh_lz[m]   = 1'b0;
                exp_an[m]  = 4'hF;
                exp_seg[m] = 8'hFF;
                exp_fd[m]  = 1'b0;
            end else begin
                exp_fd[m]  = (pos[m] == 0);
                exp_an[m]  = 4'hF;
                exp_seg[m] = 8'hFF;
                if (pos[m] == 0) begin
                    sh_dv[m] = {digit3, digit2, digit1, digit0};
                    sh_dp[m] = dp;
                    sh_lz[m] = lz_blank;
                end else begin
                    m_q = pos[m] - 1;
                    m_k = m_q / (m_dc + m_bc);
                    m_r = m_q % (m_dc + m_bc);
                    if (m_r < m_dc && en) begin
                        exp_an[m]  = ~(4'b0001 << m_k);
                        exp_seg[m] = {~sh_dp[m][m_k],
                                      supp(sh_lz[m], sh_dv[m], m_k) ? 7'h7F
                                                                    : HEX7[sh_dv[m][4*m_k +: 4]]};
                    end
                end
                pos[m] = (pos[m] + 1) % m_per;
            end
        end
    end

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model an_a", {4'h0, an_a}, {4'h0, exp_an[0]});
            cmp("model seg_a", seg_a, exp_seg[0]);
            cmp("model fd_a", {7'h0, fd_a}, {7'h0, exp_fd[0]});
            cmp("model an_b", {4'h0, an_b}, {4'h0, exp_an[1]});
            cmp("model seg_b", seg_b, exp_seg[1]);
            cmp("model fd_b", {7'h0, fd_b}, {7'h0, exp_fd[1]});
            cmp("one anode b", {7'h0, $countones(~an_b) <= 1}, 8'h01);
        end
    end

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        digit3 = d3;
        digit2 = d2;
        digit1 = d1;
        digit0 = d0;
    endtask

    // Leaves cur=0 at the negedge where fd_a is seen high.
    task automatic wait_fd();
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (fd_a) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait frame_done: actual=timeout required=pulse");
        end
        cur = 0;
    endtask

    task automatic step_to(input int tgt);
        while (cur < tgt) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic frame_check(input string name, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        wait_fd();
        for (int k = 0; k < 4; k++) begin
            step_to(1 + 6 * k);
            cmp({name, " an"}, {4'h0, an_a}, {4'h0, ~(4'b0001 << k)});
            cmp({name, " seg"}, seg_a, e[k]);
        end
    endtask

    initial begin
        rst      = 1;
        set_digits(4'd3, 4'd2, 4'd1, 4'd0);
        dp       = 4'h0;
        lz_blank = 0;
        en       = 1;
        @(negedge clk);
        chk_en = 1;
        cmp("reset an", {4'h0, an_a}, 8'h0F);
        cmp("reset seg", seg_a, 8'hFF);
        cmp("reset fd", {7'h0, fd_a}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 0;

        for (int o = 1; o <= 26; o++) begin
            @(negedge clk);
            case (o)
                1: begin
                    cmp("first fd_a", {7'h0, fd_a}, 8'h01);
                    cmp("first an_a", {4'h0, an_a}, 8'h0F);
                    cmp("first seg_a", seg_a, 8'hFF);
                end
                2, 3, 4, 5: begin
                    cmp("d0 an", {4'h0, an_a}, 8'h0E);
                    cmp("d0 seg", seg_a, 8'hC0);
                end
                6, 7: cmp("blank an", {4'h0, an_a}, 8'h0F);
                8: begin
                    cmp("d1 an", {4'h0, an_a}, 8'h0D);
                    cmp("d1 seg", seg_a, 8'hF9);
                end
                14: begin
                    cmp("d2 an", {4'h0, an_a}, 8'h0B);
                    cmp("d2 seg", seg_a, 8'hA4);
                end
                20: begin
                    cmp("d3 an", {4'h0, an_a}, 8'h07);
                    cmp("d3 seg", seg_a, 8'hB0);
                end
                26: cmp("period fd_a", {7'h0, fd_a}, 8'h01);
                default: ;
            endcase
            case (o)
                2: cmp("b an0", {4'h0, an_b}, 8'h0E);
                3: cmp("b an1", {4'h0, an_b}, 8'h0D);
                4: cmp("b an2", {4'h0, an_b}, 8'h0B);
                5: cmp("b an3", {4'h0, an_b}, 8'h07);
                6: begin
                    cmp("b load an", {4'h0, an_b}, 8'h0F);
                    cmp("b period fd", {7'h0, fd_b}, 8'h01);
                end
                default: ;
            endcase
        end

        set_digits(4'd0, 4'd0, 4'd0, 4'd5);
        lz_blank = 1;
        frame_check("lz 0005", 8'h92, 8'hFF, 8'hFF, 8'hFF);
        set_digits(4'd0, 4'd7, 4'd0, 4'd0);
        frame_check("lz 0700", 8'hC0, 8'hC0, 8'hF8, 8'hFF);

        lz_blank = 0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd8);
        wait_fd();
        step_to(1);
        cmp("shadow old an", {4'h0, an_a}, 8'h0E);
        cmp("shadow old seg", seg_a, 8'h80);
        step_to(8);
        digit0 = 4'd1;
        step_to(20);
        cmp("shadow held seg", seg_a, 8'hC0);
        wait_fd();
        step_to(1);
        cmp("shadow new seg", seg_a, 8'hF9);

        dp = 4'b0100;
        set_digits(4'd0, 4'hA, 4'd0, 4'd0);
        wait_fd();
        step_to(13);
        cmp("dp an", {4'h0, an_a}, 8'h0B);
        cmp("dp seg", seg_a, 8'h08);
        en = 0;
        step_to(14);
        cmp("en off an", {4'h0, an_a}, 8'h0F);
        cmp("en off seg", seg_a, 8'hFF);
        en = 1;
        step_to(15);
        cmp("en back an", {4'h0, an_a}, 8'h0B);
        cmp("en back seg", seg_a, 8'h08);
        step_to(16);
        rst = 1;
        step_to(17);
        cmp("midrst an", {4'h0, an_a}, 8'h0F);
        cmp("midrst seg", seg_a, 8'hFF);
        cmp("midrst fd", {7'h0, fd_a}, 8'h00);
        rst = 0;
        step_to(18);
        cmp("restart fd", {7'h0, fd_a}, 8'h01);
        step_to(19);
        cmp("restart an", {4'h0, an_a}, 8'h0E);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0) begin
                digit0 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                digit1 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                digit2 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                digit3 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                dp     = 4'($urandom);
            end
            if ($urandom_range(0, 31) == 0) lz_blank = ~lz_blank;
        end
        rst = 0;
        en  = 1;
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
